// File: rtl/k2_run_controller.sv
// Run/step/breakpoint controller: debounces the step button, sequences the
// processor clock enable and counts every instruction it issues.
module k2_run_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             btn,
    input  logic [1:0]       mode,
    input  logic             bp_en,
    input  logic [7:0]       bp_value,
    input  logic [7:0]       ro,
    output logic             cpu_en,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } run_state_t;

    run_state_t cur_state;
    run_state_t nxt_state;

    logic            btn_meta;
    logic            btn_sync;
    logic            btn_level;
    logic            btn_level_d;
    logic [DB_W-1:0] db_cnt;
    logic            press;
    logic            issued_last;
    logic            mode_run;
    logic            mode_step;
    logic            bp_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    // The accepted level only flips after an unbroken run of disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level   <= 1'b0;
            btn_level_d <= 1'b0;
            db_cnt      <= '0;
        end else begin
            btn_level_d <= btn_level;
            if (btn_sync != btn_level) begin
                if (db_cnt == DB_LAST) begin
                    btn_level <= btn_sync;
                    db_cnt    <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press     = btn_level & ~btn_level_d;
    assign mode_run  = (mode == 2'b01);
    assign mode_step = (mode == 2'b10);

    // ro has just been written by the instruction issued last cycle.
    assign bp_hit = issued_last & bp_en & (ro == bp_value);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state   <= ST_HALT;
            issued_last <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            issued_last <= cpu_en;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        if (bp_hit) begin
            nxt_state = ST_BREAK;
        end else begin
            unique case (cur_state)
                ST_HALT: begin
                    if (mode_run) begin
                        nxt_state = ST_RUN;
                    end else if (mode_step && press) begin
                        nxt_state = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (!mode_run) begin
                        nxt_state = ST_HALT;
                    end
                end
                ST_STEP: begin
                    if (cpu_en) begin
                        nxt_state = ST_HALT;
                    end
                end
                ST_BREAK: begin
                    if (press) begin
                        nxt_state = mode_run ? ST_RUN : ST_HALT;
                    end
                end
            endcase
        end
    end

    // Blocking on issued_last keeps enables at least one idle cycle apart.
    always_comb begin
        cpu_en = 1'b0;
        unique case (cur_state)
            ST_RUN:   cpu_en = tick & mode_run & ~issued_last;
            ST_STEP:  cpu_en = tick & ~issued_last;
            ST_HALT:  cpu_en = 1'b0;
            ST_BREAK: cpu_en = 1'b0;
        endcase
        halted = (cur_state != ST_RUN);
        state  = cur_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= '0;
        end else if (cpu_en) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule
